// File: rtl/nibble_serial_addsub.sv
// Nibble-serial two's-complement add/subtract: one 4-bit slice per cycle, LSB nibble first,
// with the inter-nibble carry held in a register and a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// RUN   | processing nibble idx, busy=1
// DONE  | one-cycle done pulse, results valid
module nibble_serial_addsub #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             M,
  input  logic [4*NIB-1:0] A,
  input  logic [4*NIB-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [4*NIB-1:0] Sum,
  output logic             C_out,
  output logic             ov
);

  localparam int W  = 4 * NIB;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [W-1:0]   a_q, b_q, work, work_next, a_sh, b_sh;
  logic           m_q, carry;
  logic [IW-1:0]  idx;
  logic [3:0]     a_nib, b_nib, s, low;
  logic [1:0]     high;
  logic           c3, c4, last;

  // Slice split at bit 3 so the carry into the MSB is available for overflow.
  always_comb begin
    a_sh  = a_q >> {idx, 2'b00};
    b_sh  = b_q >> {idx, 2'b00};
    a_nib = a_sh[3:0];
    b_nib = b_sh[3:0] ^ {4{m_q}};
    low   = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry};
    c3    = low[3];
    high  = {1'b0, a_nib[3]} + {1'b0, b_nib[3]} + {1'b0, c3};
    c4    = high[1];
    s     = {high[0], low[2:0]};
    work_next = work;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) work_next[i*4 +: 4] = s;
    end
    last = (idx == IW'(NIB - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      work  <= '0;
      Sum   <= '0;
      C_out <= 1'b0;
      ov    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            m_q   <= M;
            carry <= M;
            idx   <= '0;
            work  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          work  <= work_next;
          carry <= c4;
          if (last) begin
            Sum   <= work_next;
            C_out <= c4;
            ov    <= c3 ^ c4;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub: NIB=4 vector table, handshake and reset corners,
// and an exhaustive NIB=1 sweep against an arithmetic reference.
module tb_nibble_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start4, m4, busy4, done4, c4_o, ov4;
  logic [15:0] a4, b4, sum4;
  logic        start1, m1, busy1, done1, c1_o, ov1;
  logic [3:0]  a1, b1, sum1;

  nibble_serial_addsub #(.NIB(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .M(m4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .Sum(sum4), .C_out(c4_o), .ov(ov4)
  );

  nibble_serial_addsub #(.NIB(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .M(m1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .Sum(sum1), .C_out(c1_o), .ov(ov1)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_sum4;

  typedef struct {
    logic [15:0] a, b;
    logic        m;
    logic [15:0] s;
    logic        c, o;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic m,
                     input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    lat = -1;
    @(negedge clk);
    a4 = a; b4 = b; m4 = m; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0; a4 = ~a; b4 = ~b; m4 = ~m;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("strobe_overlap4", {31'b0, busy4 & done4}, 0);
      if (c <= 4) begin
        chk("busy_run4", {31'b0, busy4}, 1);
        chk("sum_hold4", {16'b0, sum4}, {16'b0, prev_sum4});
      end
      if (done4) begin
        lat = c;
        chk("sum4", {16'b0, sum4}, {16'b0, es});
        chk("cout4", {31'b0, c4_o}, {31'b0, ec});
        chk("ov4", {31'b0, ov4}, {31'b0, eo});
        break;
      end
    end
    chk("latency4", lat, 5);
    @(negedge clk);
    chk("done_pulse4", {30'b0, done4, busy4}, 0);
    prev_sum4 = es;
  endtask

  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic m);
    int lat;
    logic [3:0] bx, es;
    logic [4:0] full;
    logic eo;
    bx   = b ^ {4{m}};
    full = {1'b0, a} + {1'b0, bx} + {4'b0, m};
    es   = full[3:0];
    eo   = (a[3] == bx[3]) && (es[3] != a[3]);
    lat  = -1;
    @(negedge clk);
    a1 = a; b1 = b; m1 = m; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; a1 = ~a; b1 = ~b; m1 = ~m;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) chk("busy_run1", {31'b0, busy1}, 1);
      if (done1) begin
        lat = c;
        chk("sum1", {28'b0, sum1}, {28'b0, es});
        chk("cout1", {31'b0, c1_o}, {31'b0, full[4]});
        chk("ov1", {31'b0, ov1}, {31'b0, eo});
        break;
      end
    end
    chk("latency1", lat, 2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; m4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; m1 = 1'b0;
    prev_sum4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs4", {12'b0, busy4, done4, c4_o, ov4, sum4}, 0);
    chk("reset_outs1", {24'b0, busy1, done1, c1_o, ov1, sum1}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      op4(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].s, vecs[i].c, vecs[i].o);

    // start held high: second op must pick up operands changed mid-run
    dn = 0;
    @(negedge clk);
    a4 = 16'h0001; b4 = 16'h0001; m4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) begin a4 = 16'hFFFF; b4 = 16'hFFFF; end
      chk("hs_strobe_overlap", {31'b0, busy4 & done4}, 0);
      if (done4) begin
        dn++;
        if (dn == 1) begin
          chk("hs_done1_cycle", c, 5);
          chk("hs_sum1", {16'b0, sum4}, 32'h0002);
          chk("hs_cout1", {31'b0, c4_o}, 0);
        end else begin
          chk("hs_done2_cycle", c, 11);
          chk("hs_sum2", {16'b0, sum4}, 32'hFFFE);
          chk("hs_cout2", {31'b0, c4_o}, 1);
          chk("hs_ov2", {31'b0, ov4}, 0);
        end
      end
    end
    start4 = 1'b0;
    chk("hs_done_count", dn, 2);

    // reset asserted in cycle 2 of a run
    @(negedge clk);
    a4 = 16'h7FFF; b4 = 16'h0001; m4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_outs", {13'b0, busy4, done4, c4_o, sum4}, 0);
    chk("mid_reset_ov", {31'b0, ov4}, 0);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done4) dn++;
    end
    chk("mid_reset_no_done", dn, 0);
    prev_sum4 = '0;
    op4(16'hABCD, 16'h1111, 1'b1, 16'h9ABC, 1'b1, 1'b0);

    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          op1(4'(a), 4'(b), 1'(m));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
